// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants, sync polarity names and the segment
// decoder shared by the timing generator.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  // Order inside a line (or a frame): active, front porch, sync, back porch.
  typedef enum logic [1:0] {
    SEG_ACTIVE = 2'd0,
    SEG_FP     = 2'd1,
    SEG_SYNC   = 2'd2,
    SEG_BP     = 2'd3
  } seg_t;

  // Signals that travel down the alignment delay line together.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_bus_t;

  function automatic seg_t seg_of(input int pos, input int act, input int fp,
                                  input int sync);
    seg_t seg;
    if (pos < act)
      seg = SEG_ACTIVE;
    else if (pos < act + fp)
      seg = SEG_FP;
    else if (pos < act + fp + sync)
      seg = SEG_SYNC;
    else
      seg = SEG_BP;
    return seg;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// PIPE-deep shift register that advances only on the pixel tick; it lines the
// sync/blank signals up with the character ROM latency. PIPE=0 is a wire.
module vga_sync_delay #(
  parameter int W    = 3,
  parameter int PIPE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic [W-1:0] din,
  input  logic [W-1:0] rst_val,
  output logic [W-1:0] dout
);

  generate
    if (PIPE == 0) begin : g_bypass
      logic pipe0_unused;
      assign pipe0_unused = ^{clk, reset, tick, rst_val};
      assign dout = din;
    end else begin : g_shift
      logic [W-1:0] stage [PIPE];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE; i++) stage[i] <= rst_val;
        end else if (tick) begin
          stage[0] <= din;
          for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[PIPE-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel divider, h/v counters, registered sync,
// blank and coordinate decodes, line/frame strobes and an aligned delayed copy.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = POL_ACTIVE_LOW,
  parameter logic VS_POL   = POL_ACTIVE_LOW,
  parameter int   PIPE     = 2,
  parameter int   X_W      = 10,
  parameter int   Y_W      = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic           pix_tick,
  output logic [X_W-1:0] h_cnt,
  output logic [Y_W-1:0] v_cnt,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           video_on,
  output logic           hsync,
  output logic           vsync,
  output logic           hsync_d,
  output logic           vsync_d,
  output logic           video_on_d,
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div, div_nxt;
  logic             div_last, tick, h_wrap, v_wrap;
  logic [X_W-1:0]   h_nxt;
  logic [Y_W-1:0]   v_nxt;
  seg_t             h_seg, v_seg;
  logic             video_nxt, hsync_nxt, vsync_nxt;

  // pix_tick is the only qualifier: every counter and decode output changes
  // on the clk edge that raises pix_tick, and nowhere else.
  assign div_last = (div == DIV_W'(CLK_DIV - 1));
  assign h_wrap   = (h_cnt == X_W'(H_TOTAL - 1));
  assign v_wrap   = (v_cnt == Y_W'(V_TOTAL - 1));

  always_comb begin
    tick    = en && div_last;
    div_nxt = div;
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    if (en) div_nxt = div_last ? '0 : div + DIV_W'(1);
    if (tick) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : v_cnt + Y_W'(1);
      end else begin
        h_nxt = h_cnt + X_W'(1);
      end
    end
  end

  // Decode the value being loaded so registered outputs carry no extra lag.
  always_comb begin
    h_seg     = seg_of(int'(h_nxt), H_ACTIVE, H_FP, H_SYNC);
    v_seg     = seg_of(int'(v_nxt), V_ACTIVE, V_FP, V_SYNC);
    video_nxt = (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);
    hsync_nxt = (h_seg == SEG_SYNC) ? HS_POL : ~HS_POL;
    vsync_nxt = (v_seg == SEG_SYNC) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      pixel_x     <= video_nxt ? h_nxt : '0;
      pixel_y     <= video_nxt ? v_nxt : '0;
      video_on    <= video_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      pix_tick    <= tick;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
    end
  end

  sync_bus_t cur_bus, dly_bus, rst_bus;

  assign cur_bus = '{hsync: hsync, vsync: vsync, video_on: video_on};
  assign rst_bus = '{hsync: ~HS_POL, vsync: ~VS_POL, video_on: 1'b0};

  vga_sync_delay #(
    .W    ($bits(sync_bus_t)),
    .PIPE (PIPE)
  ) u_sync_delay (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .din     (cur_bus),
    .rst_val (rst_bus),
    .dout    (dly_bus)
  );

  assign hsync_d    = dly_bus.hsync;
  assign vsync_d    = dly_bus.vsync;
  assign video_on_d = dly_bus.video_on;

endmodule
